// File: rtl/memory_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_bus_pkg
// Desc    : Shared types for the loader/CPU main-memory arbiter.
// Rev     : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SER_OWN    = 2'd1,
        CPU_OWN    = 2'd2,
        SER_LOCKED = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_SER = 1'b0,
        OWNER_CPU = 1'b1
    } owner_t;

    typedef struct packed {
        logic                we;
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/memory_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : memory_bus_arbiter_if
// Desc      : Loader, CPU and memory signals around the arbiter. The master
//             side is the environment (requesters plus memory block).
// Rev       : 1.0 - initial release
// ============================================================================
interface memory_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ser_req;
    logic              ser_we;
    logic [ADDR_W-1:0] ser_addr;
    logic [DATA_W-1:0] ser_wdata;
    logic              ser_lock;
    logic              ser_ack;
    logic              ser_rvalid;
    logic [DATA_W-1:0] ser_rdata;
    logic              ser_err;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ser_req, ser_we, ser_addr, ser_wdata, ser_lock,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata,
        output ser_ack, ser_rvalid, ser_rdata, ser_err,
        output cpu_ack, cpu_rvalid, cpu_rdata, cpu_stall,
        output mem_we, mem_re, mem_addr, mem_wdata
    );

    modport master (
        output ser_req, ser_we, ser_addr, ser_wdata, ser_lock,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata,
        input  ser_ack, ser_rvalid, ser_rdata, ser_err,
        input  cpu_ack, cpu_rvalid, cpu_rdata, cpu_stall,
        input  mem_we, mem_re, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/memory_bus_arbiter_read_return.sv
`default_nettype none
// ============================================================================
// Module : mem_read_return
// Desc   : Tracks the owner of the read issued last cycle and steers the
//          memory's registered read data to that port.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_read_return
    import mem_bus_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  owner_t            issue_owner,
    input  logic              issue_zero,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ser_rvalid,
    output logic [DATA_W-1:0] ser_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata
);
    logic              r_valid;
    owner_t            r_owner;
    logic              r_zero;
    logic [DATA_W-1:0] r_ser_hold;
    logic [DATA_W-1:0] r_cpu_hold;
    logic [DATA_W-1:0] w_data;

    // Dropped out-of-range loader reads still return, but as zero.
    assign w_data     = r_zero ? '0 : mem_rdata;
    assign ser_rvalid = ~rst & r_valid & (r_owner == OWNER_SER);
    assign cpu_rvalid = ~rst & r_valid & (r_owner == OWNER_CPU);
    assign ser_rdata  = rst ? '0 : (ser_rvalid ? w_data : r_ser_hold);
    assign cpu_rdata  = rst ? '0 : (cpu_rvalid ? w_data : r_cpu_hold);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_owner    <= OWNER_SER;
            r_zero     <= 1'b0;
            r_ser_hold <= '0;
            r_cpu_hold <= '0;
        end else begin
            r_valid <= issue_valid;
            r_owner <= issue_owner;
            r_zero  <= issue_zero;
            if (ser_rvalid) r_ser_hold <= w_data;
            if (cpu_rvalid) r_cpu_hold <= w_data;
        end
    end
endmodule
`default_nettype wire

// File: rtl/memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : memory_bus_arbiter
// Desc   : One-access-per-cycle arbiter sharing main memory between the serial
//          loader and the CPU, with loader lock and bounded loader bursts.
// Rev    : 1.0 - initial release
// ============================================================================
module memory_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int MEM_WORDS = 4096
) (
    input  logic                clk,
    input  logic                rst,
    memory_bus_arbiter_if.slave bus
);
    localparam int                 c_CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_BURST_MAX = c_CNT_W'(MAX_BURST);

    arb_state_t         r_state;
    arb_state_t         w_next_state;
    logic [c_CNT_W-1:0] r_burst_cnt;
    logic [c_CNT_W-1:0] w_burst_cnt_nxt;
    logic               w_grant_ser;
    logic               w_grant_cpu;
    logic               w_ser_in_range;
    logic               w_mem_en;
    mem_req_t           w_req;

    assign w_ser_in_range = (bus.ser_addr < ADDR_W'(MEM_WORDS));

    // The cycle the lock is released grants nothing; arbitration resumes from IDLE.
    always_comb begin
        w_grant_ser = 1'b0;
        w_grant_cpu = 1'b0;
        if (!rst) begin
            if (bus.ser_lock) begin
                w_grant_ser = bus.ser_req;
            end else if (r_state != SER_LOCKED) begin
                if (bus.ser_req && bus.cpu_req) begin
                    if (r_burst_cnt == c_BURST_MAX) w_grant_cpu = 1'b1;
                    else                            w_grant_ser = 1'b1;
                end else begin
                    w_grant_ser = bus.ser_req;
                    w_grant_cpu = bus.cpu_req;
                end
            end
        end
    end

    always_comb begin
        w_next_state = IDLE;
        if (bus.ser_lock)      w_next_state = SER_LOCKED;
        else if (w_grant_ser)  w_next_state = SER_OWN;
        else if (w_grant_cpu)  w_next_state = CPU_OWN;

        w_burst_cnt_nxt = r_burst_cnt;
        if (!bus.cpu_req || w_grant_cpu)
            w_burst_cnt_nxt = '0;
        else if (w_grant_ser && !bus.ser_lock && r_burst_cnt != c_BURST_MAX)
            w_burst_cnt_nxt = r_burst_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    always_comb begin
        w_req = '0;
        if (w_grant_ser) begin
            w_req.we    = bus.ser_we;
            w_req.addr  = bus.ser_addr;
            w_req.wdata = bus.ser_wdata;
        end else if (w_grant_cpu) begin
            w_req.we    = bus.cpu_we;
            w_req.addr  = bus.cpu_addr;
            w_req.wdata = bus.cpu_wdata;
        end
    end

    assign w_mem_en      = w_grant_cpu | (w_grant_ser & w_ser_in_range);
    assign bus.mem_we    = w_mem_en & w_req.we;
    assign bus.mem_re    = w_mem_en & ~w_req.we;
    assign bus.mem_addr  = w_mem_en ? w_req.addr  : '0;
    assign bus.mem_wdata = w_mem_en ? w_req.wdata : '0;

    assign bus.ser_ack   = w_grant_ser;
    assign bus.cpu_ack   = w_grant_cpu;
    assign bus.ser_err   = w_grant_ser & ~w_ser_in_range;
    assign bus.cpu_stall = ~rst & ((bus.cpu_req & ~w_grant_cpu) | bus.ser_lock);

    mem_read_return #(
        .DATA_W (DATA_W)
    ) u_read_return (
        .clk         (clk),
        .rst         (rst),
        .issue_valid ((w_grant_ser | w_grant_cpu) & ~w_req.we),
        .issue_owner (w_grant_cpu ? OWNER_CPU : OWNER_SER),
        .issue_zero  (w_grant_ser & ~w_ser_in_range),
        .mem_rdata   (bus.mem_rdata),
        .ser_rvalid  (bus.ser_rvalid),
        .ser_rdata   (bus.ser_rdata),
        .cpu_rvalid  (bus.cpu_rvalid),
        .cpu_rdata   (bus.cpu_rdata)
    );
endmodule
`default_nettype wire

// File: tb/tb_memory_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_memory_bus_arbiter
// Desc   : Scoreboard bench: driver+reference model push expectations, monitor
//          pops and compares against the arbiter outputs.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_memory_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int MEM_WORDS = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    memory_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] init_val(int i);
        if (i == 16) return 32'hDEAD_BEEF;
        return 32'h5A5A_0000 ^ (i * 32'h0001_0003);
    endfunction

    // Memory block with 1-cycle registered read
    logic [DATA_W-1:0] env_mem [MEM_WORDS];
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) env_mem[i] <= init_val(i);
        bus.mem_rdata <= '0;
    end
    always @(posedge clk) begin
        if (bus.mem_we) env_mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= env_mem[bus.mem_addr[11:0]];
    end

    typedef struct {
        int          cyc;
        bit          in_rst;
        bit          ser_ack, cpu_ack, ser_err, cpu_stall, mem_we, mem_re;
        logic [31:0] mem_addr, mem_wdata;
    } cyc_exp_t;

    typedef struct {
        int          cyc;
        bit          cpu;
        logic [31:0] data;
    } rd_exp_t;

    cyc_exp_t    cyc_q[$];
    rd_exp_t     rd_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    // Reference state
    logic [31:0] ref_mem [MEM_WORDS];
    int          streak;        // loader grants since the waiting CPU was last served
    bit          prev_lock;
    bit          g_sack, g_cack;

    // Request holders
    bit          t_rst = 1'b1;
    bit          s_req, s_we, s_lock, c_req, c_we;
    logic [31:0] s_addr, s_wdata, c_addr, c_wdata;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_ser(bit we, logic [31:0] addr, logic [31:0] wd);
        s_req = 1'b1; s_we = we; s_addr = addr; s_wdata = wd;
    endtask

    task automatic set_cpu(bit we, logic [31:0] addr, logic [31:0] wd);
        c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wd;
    endtask

    task automatic step();
        cyc_exp_t    e;
        rd_exp_t     r;
        bit          gs, gc, inr, we;
        logic [31:0] a, wd;
        @(negedge clk);
        cyc++;
        rst           = t_rst;
        bus.ser_req   = s_req;  bus.ser_we = s_we;  bus.ser_addr = s_addr;
        bus.ser_wdata = s_wdata; bus.ser_lock = s_lock;
        bus.cpu_req   = c_req;  bus.cpu_we = c_we;  bus.cpu_addr = c_addr;
        bus.cpu_wdata = c_wdata;
        e = '{cyc: cyc, mem_addr: 32'h0, mem_wdata: 32'h0, default: 1'b0};
        gs = 1'b0; gc = 1'b0;
        if (t_rst) begin
            e.in_rst = 1'b1; streak = 0; prev_lock = 1'b0; rd_q.delete();
        end else begin
            if (s_lock) gs = s_req;
            else if (!prev_lock) begin
                if (s_req && c_req) begin
                    if (streak == MAX_BURST) gc = 1'b1; else gs = 1'b1;
                end else begin
                    gs = s_req; gc = c_req;
                end
            end
            inr         = (s_addr < MEM_WORDS);
            e.ser_ack   = gs;
            e.cpu_ack   = gc;
            e.ser_err   = gs && !inr;
            e.cpu_stall = (c_req && !gc) || s_lock;
            we = gs ? s_we : c_we;
            a  = gs ? s_addr : c_addr;
            wd = gs ? s_wdata : c_wdata;
            if ((gs && inr) || gc) begin
                e.mem_we = we; e.mem_re = !we; e.mem_addr = a; e.mem_wdata = wd;
                if (we) ref_mem[a[11:0]] = wd;
                else begin
                    r = '{cyc: cyc, cpu: gc, data: ref_mem[a[11:0]]};
                    rd_q.push_back(r);
                end
            end else if (gs && !we) begin
                r = '{cyc: cyc, cpu: 1'b0, data: 32'h0};
                rd_q.push_back(r);
            end
            if (!c_req || gc) streak = 0;
            else if (gs && !s_lock && streak < MAX_BURST) streak++;
            prev_lock = s_lock;
        end
        cyc_q.push_back(e);
        g_sack = gs; g_cack = gc;
    endtask

    task automatic tick();
        step();
        if (g_sack) s_req = 1'b0;
        if (g_cack) c_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (s_req || c_req); i++) tick();
    endtask

    // Monitor
    initial begin
        cyc_exp_t    e;
        rd_exp_t     r;
        logic [31:0] exp_sh, exp_ch;
        exp_sh = '0; exp_ch = '0;
        forever begin
            @(negedge clk);
            #3;
            if (cyc_q.size() == 0) continue;
            e = cyc_q.pop_front();
            if (e.in_rst) begin
                chk("reset_ctrl", {bus.ser_ack, bus.ser_rvalid, bus.ser_err, bus.cpu_ack,
                                   bus.cpu_rvalid, bus.cpu_stall, bus.mem_we, bus.mem_re}, 64'h0);
                chk("reset_rdata", {bus.ser_rdata, bus.cpu_rdata}, 64'h0);
                chk("reset_mem", {bus.mem_addr, bus.mem_wdata}, 64'h0);
                exp_sh = '0; exp_ch = '0;
            end else begin
                chk("ctrl{sack,cack,serr,stall,we,re}",
                    {bus.ser_ack, bus.cpu_ack, bus.ser_err, bus.cpu_stall, bus.mem_we, bus.mem_re},
                    {e.ser_ack, e.cpu_ack, e.ser_err, e.cpu_stall, e.mem_we, e.mem_re});
                if (e.mem_we || e.mem_re) chk("mem_addr", bus.mem_addr, e.mem_addr);
                if (e.mem_we) chk("mem_wdata", bus.mem_wdata, e.mem_wdata);
                if (bus.ser_rvalid && bus.cpu_rvalid) begin
                    n_tests++; n_fail++;
                    $display("FAIL dual_rvalid cyc=%0d actual=both required=one", e.cyc);
                end else if (bus.ser_rvalid || bus.cpu_rvalid) begin
                    if (rd_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL spurious_rvalid cyc=%0d actual=ser%0b/cpu%0b required=none",
                                 e.cyc, bus.ser_rvalid, bus.cpu_rvalid);
                    end else begin
                        r = rd_q.pop_front();
                        chk("rvalid_owner_cpu", bus.cpu_rvalid, r.cpu);
                        chk("rvalid_latency", e.cyc - r.cyc, 1);
                        if (r.cpu) begin
                            chk("cpu_rdata", bus.cpu_rdata, r.data); exp_ch = r.data;
                        end else begin
                            chk("ser_rdata", bus.ser_rdata, r.data); exp_sh = r.data;
                        end
                    end
                end
                while (rd_q.size() > 0 && rd_q[0].cyc + 1 < e.cyc) begin
                    n_tests++; n_fail++;
                    $display("FAIL missing_rvalid cyc=%0d actual=none required=read_from_cyc_%0d",
                             e.cyc, rd_q[0].cyc);
                    void'(rd_q.pop_front());
                end
                if (!bus.ser_rvalid) chk("ser_rdata_hold", bus.ser_rdata, exp_sh);
                if (!bus.cpu_rvalid) chk("cpu_rdata_hold", bus.cpu_rdata, exp_ch);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        int lock_left;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_val(i);
        s_req = 0; s_we = 0; s_lock = 0; c_req = 0; c_we = 0;
        s_addr = '0; s_wdata = '0; c_addr = '0; c_wdata = '0;
        streak = 0; prev_lock = 0;

        // Reset with both ports requesting; loader wins on release
        t_rst = 1'b1;
        set_ser(1'b1, 32'h64, 32'h1111_2222);
        set_cpu(1'b0, 32'hC8, 32'h0);
        repeat (3) step();
        t_rst = 1'b0;
        tick();
        drain();
        tick();

        // CPU read with loader idle
        set_cpu(1'b0, 32'h10, 32'h0);
        tick(); tick();

        // Continuous contention
        for (int k = 0; k < 15; k++) begin
            if (!s_req) set_ser(1'b1, 32'h100 + k, $urandom);
            if (!c_req) set_cpu(1'b0, 32'h200 + k, 32'h0);
            tick();
        end
        drain(); tick();

        // Locked upload of 10 words with CPU waiting
        s_lock = 1'b1;
        set_cpu(1'b0, 32'h20, 32'h0);
        for (int k = 0; k < 10; k++) begin
            set_ser(1'b1, k, $urandom);
            tick();
        end
        s_lock = 1'b0; s_req = 1'b0;
        tick(); tick();
        drain(); tick();

        // Out-of-range loader write and read
        set_ser(1'b1, MEM_WORDS, 32'hBAD0_BAD0);
        tick(); tick();
        chk("oor_mem_unchanged", env_mem[0], ref_mem[0]);
        set_ser(1'b0, MEM_WORDS + 5, 32'h0);
        tick(); tick();

        // Alternating reads
        set_ser(1'b0, 32'h4, 32'h0);
        tick();
        set_cpu(1'b0, 32'h8, 32'h0);
        tick(); tick(); tick();

        // Reset while a read is in flight
        set_cpu(1'b0, 32'h30, 32'h0);
        tick();
        t_rst = 1'b1; tick();
        t_rst = 1'b0; tick(); tick();

        // Randomised traffic
        lock_left = 0;
        for (int k = 0; k < 600; k++) begin
            if (lock_left == 0 && $urandom_range(0, 39) == 0) lock_left = $urandom_range(3, 12);
            s_lock = (lock_left > 0);
            if (lock_left > 0) lock_left--;
            if (!s_req && $urandom_range(0, 3) != 0)
                set_ser($urandom_range(0, 1) == 1,
                        ($urandom_range(0, 19) == 0) ? MEM_WORDS + $urandom_range(0, 3)
                                                     : $urandom_range(0, 63),
                        $urandom);
            if (!c_req && $urandom_range(0, 2) != 0)
                set_cpu($urandom_range(0, 1) == 1, $urandom_range(0, 63), $urandom);
            tick();
        end
        s_lock = 1'b0;
        tick();
        drain();
        repeat (3) tick();
        #8;
        chk("read_queue_drained", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
